// File: rtl/csr_pkg.sv
// ============================================================================
// Module : csr_pkg
// Brief  : Shared CSR addresses, operation encoding and mcause helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package csr_pkg;

  localparam logic [11:0] c_ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] c_ADDR_MIE      = 12'h304;
  localparam logic [11:0] c_ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] c_ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] c_ADDR_MEPC     = 12'h341;
  localparam logic [11:0] c_ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] c_ADDR_MIP      = 12'h344;
  localparam logic [11:0] c_ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] c_ADDR_MCYCLEH  = 12'hB80;

  localparam int          c_MSTATUS_MIE  = 3;
  localparam int          c_MSTATUS_MPIE = 7;
  localparam int          c_IRQ_BASE     = 16;
  localparam logic [31:0] c_UNMAPPED     = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Interrupt cause: MSB set, code is the mip bit position of the line.
  function automatic logic [31:0] mcause_irq(input logic [3:0] idx);
    return {1'b1, 26'b0, 5'(5'd16 + {1'b0, idx})};
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_prio_enc.sv
// ============================================================================
// Module : csr_prio_enc
// Brief  : Lowest-index-wins priority encoder with valid flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_prio_enc #(
  parameter int N = 1
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [3:0]   idx
);

  always_comb begin
    valid = |req;
    idx   = 4'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = 4'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/csr_unit.sv
// ============================================================================
// Module : csr_unit
// Brief  : Machine-mode CSR file with prioritised interrupts and mcycle.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module csr_unit
  import csr_pkg::*;
#(
  parameter int          NUM_IRQ    = 1,
  parameter bit          VECTORED   = 1'b0,
  parameter logic [31:0] MTVEC_RST  = 32'h0,
  parameter bit          HAS_MCYCLE = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [11:0]        ADDR,
  input  logic [1:0]         csr_op,
  input  logic [31:0]        WD,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               int_taken,
  input  logic               mret_exec,
  input  logic [31:0]        PC,
  output logic [31:0]        RD,
  output logic               int_req,
  output logic [31:0]        trap_vec,
  output logic [31:0]        mepc
);

  localparam logic [31:0] c_MSTATUS_MASK = (32'h1 << c_MSTATUS_MIE) | (32'h1 << c_MSTATUS_MPIE);
  localparam logic [31:0] c_MIE_MASK     = ((32'h1 << NUM_IRQ) - 32'h1) << c_IRQ_BASE;
  localparam logic [31:0] c_ALIGN_MASK   = 32'hFFFF_FFFC;

  logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mip;
  logic [31:0] w_mcycle_lo, w_mcycle_hi;
  logic [31:0] w_old, w_wval, w_pend, w_irq_vec;
  logic        w_we, w_take, w_pend_valid;
  logic [3:0]  w_cause_idx;

  assign w_irq_vec = 32'(irq) << c_IRQ_BASE;
  assign w_pend    = r_mip & r_mie;

  csr_prio_enc #(.N(NUM_IRQ)) u_prio (
    .req   (w_pend[c_IRQ_BASE +: NUM_IRQ]),
    .valid (w_pend_valid),
    .idx   (w_cause_idx)
  );

  assign int_req  = r_mstatus[c_MSTATUS_MIE] & w_pend_valid;
  assign w_take   = int_taken & int_req;
  assign trap_vec = VECTORED ? (r_mtvec + {26'b0, w_cause_idx, 2'b00}) : r_mtvec;
  assign mepc     = r_mepc;
  assign RD       = w_old;

  always_comb begin
    w_old = c_UNMAPPED;
    case (ADDR)
      c_ADDR_MSTATUS:  w_old = r_mstatus;
      c_ADDR_MIE:      w_old = r_mie;
      c_ADDR_MTVEC:    w_old = r_mtvec;
      c_ADDR_MSCRATCH: w_old = r_mscratch;
      c_ADDR_MEPC:     w_old = r_mepc;
      c_ADDR_MCAUSE:   w_old = r_mcause;
      c_ADDR_MIP:      w_old = r_mip;
      c_ADDR_MCYCLE:   w_old = w_mcycle_lo;
      c_ADDR_MCYCLEH:  w_old = w_mcycle_hi;
      default:         w_old = c_UNMAPPED;
    endcase
  end

  always_comb begin
    w_we   = 1'b1;
    w_wval = w_old;
    case (csr_op_e'(csr_op))
      CSR_OP_RW: w_wval = WD;
      CSR_OP_RS: w_wval = w_old | WD;
      CSR_OP_RC: w_wval = w_old & ~WD;
      default:   w_we   = 1'b0;
    endcase
  end

  // Trap entry overrides mret, which overrides a software write, on shared fields.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mstatus  <= 32'h0;
      r_mie      <= 32'h0;
      r_mtvec    <= MTVEC_RST & c_ALIGN_MASK;
      r_mscratch <= 32'h0;
      r_mepc     <= 32'h0;
      r_mcause   <= 32'h0;
      r_mip      <= 32'h0;
    end else begin
      r_mip <= w_irq_vec;

      if (w_take) begin
        r_mstatus[c_MSTATUS_MPIE] <= r_mstatus[c_MSTATUS_MIE];
        r_mstatus[c_MSTATUS_MIE]  <= 1'b0;
      end else if (mret_exec) begin
        r_mstatus[c_MSTATUS_MIE]  <= r_mstatus[c_MSTATUS_MPIE];
        r_mstatus[c_MSTATUS_MPIE] <= 1'b1;
      end else if (w_we && ADDR == c_ADDR_MSTATUS) begin
        r_mstatus <= w_wval & c_MSTATUS_MASK;
      end

      if (w_take) begin
        r_mepc   <= PC & c_ALIGN_MASK;
        r_mcause <= mcause_irq(w_cause_idx);
      end else begin
        if (w_we && ADDR == c_ADDR_MEPC)   r_mepc   <= w_wval & c_ALIGN_MASK;
        if (w_we && ADDR == c_ADDR_MCAUSE) r_mcause <= w_wval;
      end

      if (w_we && ADDR == c_ADDR_MIE)      r_mie      <= w_wval & c_MIE_MASK;
      if (w_we && ADDR == c_ADDR_MTVEC)    r_mtvec    <= w_wval & c_ALIGN_MASK;
      if (w_we && ADDR == c_ADDR_MSCRATCH) r_mscratch <= w_wval;
    end
  end

  generate
    if (HAS_MCYCLE) begin : g_mcycle
      logic [63:0] r_mcycle;

      // A write to either half replaces it and skips this cycle's increment.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_mcycle <= 64'h0;
        end else if (w_we && ADDR == c_ADDR_MCYCLE) begin
          r_mcycle[31:0] <= w_wval;
        end else if (w_we && ADDR == c_ADDR_MCYCLEH) begin
          r_mcycle[63:32] <= w_wval;
        end else begin
          r_mcycle <= r_mcycle + 64'd1;
        end
      end

      assign w_mcycle_lo = r_mcycle[31:0];
      assign w_mcycle_hi = r_mcycle[63:32];
    end else begin : g_no_mcycle
      assign w_mcycle_lo = 32'h0;
      assign w_mcycle_hi = 32'h0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_csr_unit.sv
// ============================================================================
// Module : tb_csr_unit
// Brief  : Directed self-checking bench for csr_unit (vectored and direct).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_csr_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] addr = 12'h0;
  logic [1:0]  csr_op = 2'b00;
  logic [31:0] wd = 32'h0;
  logic [3:0]  irq = 4'h0;
  logic        int_taken = 1'b0;
  logic        mret_exec = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] rd, trap_vec, mepc, rd_nv, trap_vec_nv, mepc_nv;
  logic        int_req, int_req_nv;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csr_unit #(.NUM_IRQ(4), .VECTORED(1'b1), .MTVEC_RST(32'h80), .HAS_MCYCLE(1'b1)) dut (
    .clk(clk), .reset(reset), .ADDR(addr), .csr_op(csr_op), .WD(wd), .irq(irq),
    .int_taken(int_taken), .mret_exec(mret_exec), .PC(pc),
    .RD(rd), .int_req(int_req), .trap_vec(trap_vec), .mepc(mepc)
  );

  csr_unit #(.NUM_IRQ(4), .VECTORED(1'b0), .MTVEC_RST(32'h80), .HAS_MCYCLE(1'b1)) dut_nv (
    .clk(clk), .reset(reset), .ADDR(addr), .csr_op(csr_op), .WD(wd), .irq(irq),
    .int_taken(int_taken), .mret_exec(mret_exec), .PC(pc),
    .RD(rd_nv), .int_req(int_req_nv), .trap_vec(trap_vec_nv), .mepc(mepc_nv)
  );

  task automatic csr_do(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    addr = a; csr_op = op; wd = d;
    @(posedge clk); #1;
    csr_op = 2'b00;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    addr = 12'h305; #1;
    n_vec++; if (rd !== 32'h80) begin n_bad++; $display("FAIL rst_mtvec: got %h exp %h", rd, 32'h80); end
    csr_do(12'h340, 2'b01, 32'h77);
    csr_do(12'hB00, 2'b01, 32'h123);
    addr = 12'hB00; #1;
    n_vec++; if (rd !== 32'h123) begin n_bad++; $display("FAIL mcycle_pre: got %h exp %h", rd, 32'h123); end
    reset = 1'b1; #1;
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_mcycle: got %h exp 0", rd); end
    addr = 12'h340; #1;
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_mscratch: got %h exp 0", rd); end
    addr = 12'h300; #1;
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL rst_mstatus: got %h exp 0", rd); end
    addr = 12'h305; #1;
    n_vec++; if (rd !== 32'h80) begin n_bad++; $display("FAIL rst_mtvec2: got %h exp %h", rd, 32'h80); end
    n_vec++; if (trap_vec !== 32'h80) begin n_bad++; $display("FAIL rst_trap_vec: got %h exp %h", trap_vec, 32'h80); end
    n_vec++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL rst_int_req: got %b exp 0", int_req); end
    n_vec++; if (mepc !== 32'h0) begin n_bad++; $display("FAIL rst_mepc: got %h exp 0", mepc); end
    @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic test_mstatus();
    csr_do(12'h300, 2'b10, 32'h88);
    addr = 12'h300; #1;
    n_vec++; if (rd !== 32'h88) begin n_bad++; $display("FAIL mstatus_rs: got %h exp %h", rd, 32'h88); end
    csr_do(12'h300, 2'b11, 32'h08);
    addr = 12'h300; #1;
    n_vec++; if (rd !== 32'h80) begin n_bad++; $display("FAIL mstatus_rc: got %h exp %h", rd, 32'h80); end
    csr_do(12'h300, 2'b01, 32'hFFFF_FFFF);
    addr = 12'h300; #1;
    n_vec++; if (rd !== 32'h88) begin n_bad++; $display("FAIL mstatus_rw_mask: got %h exp %h", rd, 32'h88); end
  endtask

  task automatic test_irq();
    csr_do(12'h304, 2'b01, 32'hFFFF_FFFF);
    addr = 12'h304; #1;
    n_vec++; if (rd !== 32'h000F_0000) begin n_bad++; $display("FAIL mie_mask: got %h exp %h", rd, 32'h000F_0000); end
    csr_do(12'h304, 2'b01, 32'h000A_0000);
    addr = 12'h304; #1;
    n_vec++; if (rd !== 32'h000A_0000) begin n_bad++; $display("FAIL mie_rw: got %h exp %h", rd, 32'h000A_0000); end
    csr_do(12'h300, 2'b01, 32'h08);
    irq = 4'b1010; #1;
    n_vec++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL irq_sync_delay: got %b exp 0", int_req); end
    @(posedge clk); #1;
    n_vec++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL irq_req: got %b exp 1", int_req); end
    addr = 12'h344; #1;
    n_vec++; if (rd !== 32'h000A_0000) begin n_bad++; $display("FAIL mip_read: got %h exp %h", rd, 32'h000A_0000); end
    n_vec++; if (trap_vec !== 32'h84) begin n_bad++; $display("FAIL trap_vec_idx1: got %h exp %h", trap_vec, 32'h84); end
    n_vec++; if (trap_vec_nv !== 32'h80) begin n_bad++; $display("FAIL trap_vec_nv_idx1: got %h exp %h", trap_vec_nv, 32'h80); end
    pc = 32'h106; int_taken = 1'b1;
    @(posedge clk); #1 int_taken = 1'b0;
    n_vec++; if (mepc !== 32'h104) begin n_bad++; $display("FAIL take_mepc: got %h exp %h", mepc, 32'h104); end
    addr = 12'h342; #1;
    n_vec++; if (rd !== 32'h8000_0011) begin n_bad++; $display("FAIL take_mcause: got %h exp %h", rd, 32'h8000_0011); end
    addr = 12'h300; #1;
    n_vec++; if (rd !== 32'h80) begin n_bad++; $display("FAIL take_mstatus: got %h exp %h", rd, 32'h80); end
    n_vec++; if (int_req !== 1'b0) begin n_bad++; $display("FAIL take_int_req: got %b exp 0", int_req); end
    pc = 32'h200; int_taken = 1'b1;
    @(posedge clk); #1 int_taken = 1'b0;
    n_vec++; if (mepc !== 32'h104) begin n_bad++; $display("FAIL ignored_take_mepc: got %h exp %h", mepc, 32'h104); end
    n_vec++; if (rd !== 32'h80) begin n_bad++; $display("FAIL ignored_take_mstatus: got %h exp %h", rd, 32'h80); end
  endtask

  task automatic test_mret();
    mret_exec = 1'b1;
    @(posedge clk); #1 mret_exec = 1'b0;
    addr = 12'h300; #1;
    n_vec++; if (rd !== 32'h88) begin n_bad++; $display("FAIL mret_mstatus: got %h exp %h", rd, 32'h88); end
    n_vec++; if (int_req !== 1'b1) begin n_bad++; $display("FAIL mret_int_req: got %b exp 1", int_req); end
    pc = 32'h300; int_taken = 1'b1; mret_exec = 1'b1;
    @(posedge clk); #1 int_taken = 1'b0; mret_exec = 1'b0;
    n_vec++; if (rd !== 32'h80) begin n_bad++; $display("FAIL take_vs_mret_mstatus: got %h exp %h", rd, 32'h80); end
    n_vec++; if (mepc !== 32'h300) begin n_bad++; $display("FAIL take_vs_mret_mepc: got %h exp %h", mepc, 32'h300); end
  endtask

  task automatic test_back_to_back();
    mret_exec = 1'b1;
    @(posedge clk); #1 mret_exec = 1'b0;
    addr = 12'h340; csr_op = 2'b01; wd = 32'h5A5A; pc = 32'h400; int_taken = 1'b1;
    @(posedge clk); #1 csr_op = 2'b00; int_taken = 1'b0;
    n_vec++; if (rd !== 32'h5A5A) begin n_bad++; $display("FAIL take_plus_mscratch: got %h exp %h", rd, 32'h5A5A); end
    n_vec++; if (mepc !== 32'h400) begin n_bad++; $display("FAIL take_plus_mscratch_mepc: got %h exp %h", mepc, 32'h400); end
    addr = 12'h300; #1;
    n_vec++; if (rd !== 32'h80) begin n_bad++; $display("FAIL take_plus_mscratch_mstatus: got %h exp %h", rd, 32'h80); end
  endtask

  task automatic test_vectored();
    csr_do(12'h305, 2'b01, 32'h203);
    addr = 12'h305; #1;
    n_vec++; if (rd !== 32'h200) begin n_bad++; $display("FAIL mtvec_align: got %h exp %h", rd, 32'h200); end
    irq = 4'b1000;
    @(posedge clk); #1;
    n_vec++; if (trap_vec !== 32'h20C) begin n_bad++; $display("FAIL trap_vec_idx3: got %h exp %h", trap_vec, 32'h20C); end
    n_vec++; if (trap_vec_nv !== 32'h200) begin n_bad++; $display("FAIL trap_vec_nv_idx3: got %h exp %h", trap_vec_nv, 32'h200); end
  endtask

  task automatic test_mcycle();
    csr_do(12'hB00, 2'b01, 32'hFFFF_FFFF);
    addr = 12'hB00; #1;
    n_vec++; if (rd !== 32'hFFFF_FFFF) begin n_bad++; $display("FAIL mcycle_lo_write: got %h exp %h", rd, 32'hFFFF_FFFF); end
    addr = 12'hB80; #1;
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mcycle_hi_before: got %h exp 0", rd); end
    @(posedge clk); #1;
    n_vec++; if (rd !== 32'h1) begin n_bad++; $display("FAIL mcycle_hi_carry: got %h exp 1", rd); end
    addr = 12'hB00; #1;
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mcycle_lo_wrap: got %h exp 0", rd); end
    csr_do(12'hB80, 2'b01, 32'h1234);
    addr = 12'hB00; #1;
    n_vec++; if (rd !== 32'h0) begin n_bad++; $display("FAIL mcycleh_write_suppress: got %h exp 0", rd); end
    addr = 12'hB80; #1;
    n_vec++; if (rd !== 32'h1234) begin n_bad++; $display("FAIL mcycleh_write: got %h exp %h", rd, 32'h1234); end
    @(posedge clk); #1;
    addr = 12'hB00; #1;
    n_vec++; if (rd !== 32'h1) begin n_bad++; $display("FAIL mcycle_resume: got %h exp 1", rd); end
  endtask

  task automatic test_unmapped();
    addr = 12'h7C0; #1;
    n_vec++; if (rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL unmapped_read: got %h exp %h", rd, 32'hDEAD_BEEF); end
    csr_do(12'h7C0, 2'b01, 32'hFFFF_FFFF);
    addr = 12'h340; #1;
    n_vec++; if (rd !== 32'h5A5A) begin n_bad++; $display("FAIL unmapped_mscratch: got %h exp %h", rd, 32'h5A5A); end
    addr = 12'h305; #1;
    n_vec++; if (rd !== 32'h200) begin n_bad++; $display("FAIL unmapped_mtvec: got %h exp %h", rd, 32'h200); end
    addr = 12'h300; #1;
    n_vec++; if (rd !== 32'h80) begin n_bad++; $display("FAIL unmapped_mstatus: got %h exp %h", rd, 32'h80); end
  endtask

  initial begin
    test_reset();
    test_mstatus();
    test_irq();
    test_mret();
    test_back_to_back();
    test_vectored();
    test_mcycle();
    test_unmapped();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
